// File: rtl/instr_pack.sv
// Shared definitions for the move/literal instruction group: command opcodes,
// encoder states, the literal register and the word-building functions used
// by both the encoder and the decoder side.
package instr_pack;

  typedef enum logic [1:0] {
    OP_LIT_LO = 2'd0,
    OP_LIT_HI = 2'd1,
    OP_MOV    = 2'd2,
    OP_LDI    = 2'd3
  } enc_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EMIT_HI  = 3'd1,
    EMIT_LO  = 3'd2,
    EMIT_MOV = 3'd3,
    ERR      = 3'd4
  } enc_state_t;

  // Register that literal words load into.
  localparam logic [3:0] LIT_REG = 4'd0;

  // Literal word: nib=1 loads LIT_REG[7:4], nib=0 loads LIT_REG[3:0].
  function automatic logic [8:0] f_lit(input logic nib, input logic [3:0] d);
    return {2'b00, 2'b00, nib, d};
  endfunction

  // Move word: dst <- src.
  function automatic logic [8:0] f_mov(input logic [3:0] dst, input logic [3:0] src);
    return {1'b0, dst, src};
  endfunction

  // A move whose dst[2:1] is zero would alias the literal encoding space.
  function automatic logic f_mov_dst_legal(input logic [3:0] dst);
    return (dst[2:1] != 2'b00);
  endfunction

  // LDI to r0 needs no trailing move; r1, r8 and r9 cannot be move targets.
  function automatic logic f_ldi_dst_legal(input logic [3:0] dst);
    return !((dst == 4'd1) || (dst == 4'd8) || (dst == 4'd9));
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Sequential encoder: turns register-load / move commands into 9-bit words
// for instruction memory, one word per valid/ready handshake, with a wrapping
// write address. All instr_* outputs come from registers; cmd_ready,
// instr_valid and err are decoded from the registered state.
module instr_encoder
  import instr_pack::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_dst,
  input  logic [3:0]        cmd_src,
  input  logic [7:0]        cmd_imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [8:0]        instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err
);

  enc_state_t        state_q, state_d;
  logic [3:0]        hi_nib_q, hi_nib_d;
  logic [3:0]        lo_nib_q, lo_nib_d;
  logic [3:0]        mov_dst_q, mov_dst_d;
  logic [3:0]        mov_src_q, mov_src_d;
  logic              ldi_q, ldi_d;          // HI step is followed by LO step
  logic              ldi_mov_q, ldi_mov_d;  // LO step is followed by MOV step
  logic [8:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_inc_s;

  assign addr_inc_s = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Next-state, command latching, address advance and next instruction word.
  always_comb begin
    state_d   = state_q;
    hi_nib_d  = hi_nib_q;
    lo_nib_d  = lo_nib_q;
    mov_dst_d = mov_dst_q;
    mov_src_d = mov_src_q;
    ldi_d     = ldi_q;
    ldi_mov_d = ldi_mov_q;
    addr_d    = addr_q;
    instr_d   = instr_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (enc_op_t'(cmd_op))
            OP_LIT_HI: begin
              hi_nib_d  = cmd_imm[3:0];
              ldi_d     = 1'b0;
              ldi_mov_d = 1'b0;
              state_d   = EMIT_HI;
            end
            OP_LIT_LO: begin
              lo_nib_d  = cmd_imm[3:0];
              ldi_d     = 1'b0;
              ldi_mov_d = 1'b0;
              state_d   = EMIT_LO;
            end
            OP_MOV: begin
              mov_dst_d = cmd_dst;
              mov_src_d = cmd_src;
              ldi_d     = 1'b0;
              ldi_mov_d = 1'b0;
              if (f_mov_dst_legal(cmd_dst)) begin
                state_d = EMIT_MOV;
              end else begin
                state_d = ERR;
              end
            end
            OP_LDI: begin
              hi_nib_d  = cmd_imm[7:4];
              lo_nib_d  = cmd_imm[3:0];
              mov_dst_d = cmd_dst;
              mov_src_d = LIT_REG;
              ldi_d     = 1'b1;
              ldi_mov_d = (cmd_dst != LIT_REG);
              if (f_ldi_dst_legal(cmd_dst)) begin
                state_d = EMIT_HI;
              end else begin
                state_d = ERR;
              end
            end
            default: begin
              state_d = ERR;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      EMIT_HI: begin
        if (instr_ready) begin
          addr_d  = addr_inc_s;
          state_d = ldi_q ? EMIT_LO : IDLE;
        end else begin
          state_d = EMIT_HI;
        end
      end
      EMIT_LO: begin
        if (instr_ready) begin
          addr_d  = addr_inc_s;
          state_d = ldi_mov_q ? EMIT_MOV : IDLE;
        end else begin
          state_d = EMIT_LO;
        end
      end
      EMIT_MOV: begin
        if (instr_ready) begin
          addr_d  = addr_inc_s;
          state_d = IDLE;
        end else begin
          state_d = EMIT_MOV;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The word register tracks the state being entered so instr is already
    // valid in the first EMIT cycle and holds while the state holds.
    case (state_d)
      EMIT_HI:  instr_d = f_lit(1'b1, hi_nib_d);
      EMIT_LO:  instr_d = f_lit(1'b0, lo_nib_d);
      EMIT_MOV: instr_d = f_mov(mov_dst_d, mov_src_d);
      default:  instr_d = 9'h000;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_nib_q  <= 4'd0;
      lo_nib_q  <= 4'd0;
      mov_dst_q <= 4'd0;
      mov_src_q <= 4'd0;
      ldi_q     <= 1'b0;
      ldi_mov_q <= 1'b0;
      instr_q   <= 9'h000;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      hi_nib_q  <= hi_nib_d;
      lo_nib_q  <= lo_nib_d;
      mov_dst_q <= mov_dst_d;
      mov_src_q <= mov_src_d;
      ldi_q     <= ldi_d;
      ldi_mov_q <= ldi_mov_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign instr_valid = (state_q == EMIT_HI) || (state_q == EMIT_LO) || (state_q == EMIT_MOV);
  assign err         = (state_q == ERR);
  assign instr       = instr_q;
  assign instr_addr  = addr_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder for the 9-bit CPU's move/literal group. It accepts high-level register-load and move commands over a valid/ready handshake and emits the corresponding 9-bit instruction words, one per handshake, together with an instruction-memory write address. It is the producing end of the format the control-logic decoder consumes, and sits between the bootloader/test-program source and instruction memory.

## Interface
- ADDR_W, 8, width of instruction-memory write address; address wraps modulo 2^ADDR_W.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  encoder can accept a command; high only in IDLE.
- cmd_op  in  2  enc_op_t: OP_LIT_LO, OP_LIT_HI, OP_MOV, OP_LDI.
- cmd_dst  in  4  destination register (OP_MOV, OP_LDI).
- cmd_src  in  4  source register (OP_MOV).
- cmd_imm  in  8  immediate; OP_LIT_LO/OP_LIT_HI use imm[3:0], OP_LDI uses all 8 bits.
- instr_valid  out  1  instr/instr_addr valid.
- instr_ready  in  1  downstream accepts instruction.
- instr  out  9  encoded instruction word.
- instr_addr  out  ADDR_W  address for the current instr.
- err  out  1  one-cycle pulse: illegal command rejected.

## Operation
- Encodings. All words have bit 8 = 0.
  - Literal: instr = {2'b00, 2'b00, nib, d[3:0]}. nib=1 loads [7:4] and nib=0 loads [3:0] of LIT_REG (r0).
  - Move: instr = {1'b0, dst[3:0], src[3:0]}.
- Legal move destination: dst[2:1] != 2'b00. r0, r1, r8 and r9 are illegal move destinations because their encoding aliases the literal space.
- State machine enc_state_t: IDLE, EMIT_HI, EMIT_LO, EMIT_MOV, ERR.
- IDLE. cmd_ready=1. On cmd_valid, the command is latched and the next state is chosen by op:
  - OP_LIT_HI → EMIT_HI (nibble = imm[3:0]).
  - OP_LIT_LO → EMIT_LO (nibble = imm[3:0]).
  - OP_MOV with legal dst → EMIT_MOV. OP_MOV with illegal dst → ERR.
  - OP_LDI with dst ∈ {1,8,9} → ERR. OP_LDI with any other dst → EMIT_HI (nibble = imm[7:4]), then EMIT_LO (imm[3:0]), then EMIT_MOV {dst, r0}. The EMIT_MOV step is skipped when dst = 0.
- EMIT_*. instr_valid=1 and instr is held stable until instr_ready. On the handshake, instr_addr increments (wrapping from 2^ADDR_W−1 to 0) and the FSM advances to the next step of the command, or to IDLE after the last step.
- ERR. err=1 for exactly one cycle and nothing is emitted; next state is IDLE. instr_addr is unchanged.
- cmd_* inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, cmd_ready=1, instr_valid=0, instr=9'h000, instr_addr=0, err=0.
- Command accepted on edge N → first instr_valid in cycle N+1. All outputs are registered or decoded from registered state; there is no combinational path from cmd_* to instr_*.
- Throughput: one instruction per cycle while instr_ready=1.
- Cycles per command with instr_ready tied high:
  - OP_LDI: 3 words plus 1 IDLE cycle, 4 cycles total.
  - OP_LDI to r0: 2 words, 3 cycles total.
  - OP_LIT_* and OP_MOV: 2 cycles.
  - Illegal command: 2 cycles (ERR, then IDLE).
- Back-pressure: with instr_ready=0, instr, instr_addr and state hold indefinitely.
- Reset asserted mid-command: on the next edge the pending command is discarded, instr_valid drops and instr_addr returns to 0, regardless of instr_ready.
- Address wrap is silent; no flag is raised.

## Structure
- Shared package (instr_pack): enc_op_t, enc_state_t, LIT_REG = 4'd0, and functions f_lit(nib, d) and f_mov(dst, src) returning the 9-bit words. The decoder side relies on the same constants.
- Single module with no sub-module. The encode functions live in the package so the decoder's bench can reuse them.

## Test plan
- OP_LDI dst=3 imm=8'hA5 with instr_ready=1 → words 9'h01A, 9'h005, 9'h030 at addresses 0, 1, 2; cmd_ready returns high 4 cycles after acceptance.
- OP_LDI dst=0 imm=8'h3C → words 9'h013, 9'h00C only; instr_addr advances by 2.
- OP_MOV dst=9 src=2 → err pulses for one cycle, instr_valid never asserts, instr_addr unchanged; OP_MOV dst=1 gives the same result.
- OP_MOV dst=15 src=4 with instr_ready held low for 5 cycles → instr=9'h0F4 stable all 5 cycles; exactly one address increment when ready rises.
- ADDR_W=2, four OP_LIT_LO commands (imm 1..4) followed by a fifth (imm 5) → addresses 0, 1, 2, 3, 0; fifth word is 9'h005.
- Reset asserted during EMIT_LO of an OP_LDI → next cycle instr_valid=0, instr_addr=0, cmd_ready=1; no EMIT_MOV word is emitted.
